// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide unit with architectural HI/LO.
// Executes MULT/MULTU (radix-2 shift-add) and DIV/DIVU (restoring division),
// one bit per cycle, 33 cycles from launch to result.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, op[1:0]      launch request (sampled in IDLE) and opcode
//                       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   opA, opB [31:0]     multiplicand/dividend, multiplier/divisor
//   hi_we, lo_we, wdata MTHI/MTLO direct writes (honoured only in IDLE)
//   busy, done          operation in flight, one-cycle result pulse
//   hi, lo [31:0]       HI/LO registers
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            is_div;
  logic            neg_q;    // negate product / quotient
  logic            neg_r;    // negate remainder (dividend was negative)
  logic [W-1:0]    opnd;     // |multiplicand| or |divisor|
  logic [2*W-1:0]  prod;     // product, or {unused, dividend->quotient shifter}
  logic [W-1:0]    rem;      // partial remainder

  // Magnitude for signed ops, raw value for unsigned ops
  function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic sgn);
    return (sgn && x[W-1]) ? W'(-x) : x;
  endfunction

  logic            is_signed;
  logic [W:0]      mul_sum;
  logic [W:0]      div_shift;
  logic            div_ge;
  logic [W-1:0]    rem_next;
  logic [2*W-1:0]  mul_res;
  logic [W-1:0]    q_res;
  logic [W-1:0]    r_res;

  // Per-iteration datapath and final sign correction
  always_comb begin
    is_signed = ~op[0];
    mul_sum   = {1'b0, prod[2*W-1:W]} + {1'b0, (prod[0] ? opnd : '0)};
    div_shift = {rem, prod[W-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    rem_next  = div_ge ? W'(div_shift - {1'b0, opnd}) : div_shift[W-1:0];
    mul_res   = neg_q ? (2*W)'(-prod) : prod;
    // Divide by zero: quotient forced to all ones; the remainder path already
    // reconstructs the dividend including its sign.
    if (opnd == '0) q_res = '1;
    else            q_res = neg_q ? W'(-prod[W-1:0]) : prod[W-1:0];
    r_res     = neg_r ? W'(-rem) : rem;
  end

  // Control FSM, datapath registers and HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opnd   <= '0;
      prod   <= '0;
      rem    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            state  <= CALC;
            busy   <= 1'b1;
            cnt    <= '0;
            is_div <= op[1];
            neg_q  <= is_signed & (opA[W-1] ^ opB[W-1]);
            neg_r  <= is_signed & op[1] & opA[W-1];
            rem    <= '0;
            if (op[1]) begin
              opnd <= mag(opB, is_signed);
              prod <= {{W{1'b0}}, mag(opA, is_signed)};
            end else begin
              opnd <= mag(opA, is_signed);
              prod <= {{W{1'b0}}, mag(opB, is_signed)};
            end
          end
        end
        CALC: begin
          if (is_div) begin
            prod <= {prod[2*W-1:W], prod[W-2:0], div_ge};
            rem  <= rem_next;
          end else begin
            prod <= {mul_sum, prod[W-1:1]};
          end
          cnt <= CW'(cnt + 1'b1);
          if (cnt == '1) state <= FINISH;
        end
        FINISH: begin
          if (is_div) begin
            hi <= r_res;
            lo <= q_res;
          end else begin
            hi <= mul_res[2*W-1:W];
            lo <= mul_res[W-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
